boreal_spatial_mixer: RTL and testbench

//  Parametrised N_OUT x N_IN spatial filter: u[o] = sum_i M[o][i]*(z[i]-off[i]), rounded, shifted, saturated.

---
 rtl/boreal_spatial_mixer_pkg.sv | 22 ++
 rtl/boreal_spatial_mixer_if.sv | 38 +++
 rtl/boreal_spatial_mixer_coef_dpram.sv | 22 ++
 rtl/boreal_spatial_mixer.sv | 201 ++++++++++++++++++++
 tb/tb_boreal_spatial_mixer.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/boreal_spatial_mixer_pkg.sv
// Shared constants, FSM encoding and helpers for the boreal spatial mixer.
package boreal_spatial_mixer_pkg;

    localparam logic HOST_SEL_COEF = 1'b0;
    localparam logic HOST_SEL_OFF  = 1'b1;

    typedef enum logic [2:0] {
        StIdle,
        StMac,
        StDrain,
        StFin,
        StHold
    } state_e;

    function automatic int unsigned clog2(input int unsigned val);
        int unsigned res;
        res = 0;
        while ((64'd1 << res) < 64'(val)) res++;
        return res;
    endfunction

endpackage

// File: rtl/boreal_spatial_mixer_if.sv
// Stream and host-bus signals of the boreal spatial mixer.
interface boreal_spatial_mixer_if #(
    parameter int unsigned N_IN  = 8,
    parameter int unsigned N_OUT = 2,
    parameter int unsigned DW    = 16,
    parameter int unsigned CW    = 16,
    parameter int unsigned OW    = 24
);
    import boreal_spatial_mixer_pkg::*;

    localparam int unsigned AW = clog2(N_OUT * N_IN);
    localparam int unsigned HW = (CW > DW) ? CW : DW;

    logic                  in_valid;
    logic                  in_ready;
    logic [N_IN*DW-1:0]    features;
    logic                  out_valid;
    logic                  out_ready;
    logic [N_OUT*OW-1:0]   u;
    logic                  sat_flag;
    logic                  host_we;
    logic                  host_sel;
    logic [AW-1:0]         host_addr;
    logic [HW-1:0]         host_din;
    logic                  bank_swap;
    logic                  active_bank;

    modport master (
        output in_valid, features, out_ready, host_we, host_sel, host_addr, host_din, bank_swap,
        input  in_ready, out_valid, u, sat_flag, active_bank
    );

    modport slave (
        input  in_valid, features, out_ready, host_we, host_sel, host_addr, host_din, bank_swap,
        output in_ready, out_valid, u, sat_flag, active_bank
    );

endinterface

// File: rtl/boreal_spatial_mixer_coef_dpram.sv
// Simple dual-port coefficient RAM: host write port, registered MAC read port, no reset.
module boreal_spatial_mixer_coef_dpram #(
    parameter int unsigned AddrW = 5,
    parameter int unsigned DataW = 16
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AddrW-1:0] waddr,
    input  logic [DataW-1:0] wdata,
    input  logic             re,
    input  logic [AddrW-1:0] raddr,
    output logic [DataW-1:0] rdata
);

    logic [DataW-1:0] mem [2**AddrW];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/boreal_spatial_mixer.sv
// N_OUT x N_IN spatial filter with offsets, double-buffered coefficients and round/saturate.
module boreal_spatial_mixer
    import boreal_spatial_mixer_pkg::*;
#(
    parameter int unsigned N_IN  = 8,
    parameter int unsigned N_OUT = 2,
    parameter int unsigned DW    = 16,
    parameter int unsigned CW    = 16,
    parameter int unsigned ACC_W = 40,
    parameter int unsigned SHIFT = 8,
    parameter int unsigned OW    = 24
) (
    input logic                    clk,
    input logic                    rst_n,
    boreal_spatial_mixer_if.slave  bus
);

    localparam int unsigned K     = N_OUT * N_IN;
    localparam int unsigned AW    = clog2(K);
    localparam int unsigned CNT_W = clog2(K + 1);
    localparam int unsigned ROW_W = (N_OUT > 1) ? clog2(N_OUT) : 1;
    localparam int unsigned COL_W = (N_IN > 1) ? clog2(N_IN) : 1;
    localparam int unsigned PW    = CW + DW + 1;

    localparam logic signed [ACC_W:0] RND     = ((ACC_W + 1)'(1) << SHIFT) >> 1;
    localparam logic signed [ACC_W:0] SAT_MAX = {{(ACC_W - OW + 2){1'b0}}, {(OW - 1){1'b1}}};
    localparam logic signed [ACC_W:0] SAT_MIN = {{(ACC_W - OW + 2){1'b1}}, {(OW - 1){1'b0}}};

    state_e state_q, state_d;
    logic   bank_q, bank_d;
    logic   swap_pend_q, swap_pend_d;
    logic   accept;

    logic signed [DW-1:0]    z_q        [N_IN];
    logic signed [DW-1:0]    off_q      [N_IN];
    logic signed [DW-1:0]    off_snap_q [N_IN];
    logic [CNT_W-1:0]        cnt_q;
    logic [ROW_W-1:0]        row_q, rd_row_q, prod_row_q;
    logic [COL_W-1:0]        col_q, rd_col_q;
    logic                    rd_en, rd_vld_q, prod_vld_q;
    logic [CW-1:0]           coef_raw;
    logic signed [CW-1:0]    coef_rd;
    logic signed [DW:0]      diff;
    logic signed [PW-1:0]    prod_c, prod_q;
    logic signed [ACC_W-1:0] acc_q      [N_OUT];
    logic signed [ACC_W:0]   biased     [N_OUT];
    logic signed [ACC_W:0]   shifted    [N_OUT];
    logic [N_OUT*OW-1:0]     u_c, u_q;
    logic                    sat_c, sat_q, out_valid_q;
    logic                    coef_we, off_we;

    assign coef_we = bus.host_we && (bus.host_sel == HOST_SEL_COEF) && (32'(bus.host_addr) < K);
    assign off_we  = bus.host_we && (bus.host_sel == HOST_SEL_OFF) && (32'(bus.host_addr) < N_IN);
    assign rd_en   = (state_q == StMac) && (cnt_q < CNT_W'(K));

    // Host writes always target the shadow bank, so a frame in flight never sees them.
    boreal_spatial_mixer_coef_dpram #(
        .AddrW(AW + 1),
        .DataW(CW)
    ) u_coef_ram (
        .clk  (clk),
        .we   (coef_we),
        .waddr({~bank_q, bus.host_addr}),
        .wdata(bus.host_din[CW-1:0]),
        .re   (rd_en),
        .raddr({bank_q, cnt_q[AW-1:0]}),
        .rdata(coef_raw)
    );

    assign coef_rd = signed'(coef_raw);

    always_comb begin
        state_d     = state_q;
        bank_d      = bank_q;
        swap_pend_d = swap_pend_q | bus.bank_swap;
        accept      = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (swap_pend_q || bus.bank_swap) begin
                    bank_d      = ~bank_q;
                    swap_pend_d = 1'b0;
                end
                if (bus.in_valid) begin
                    accept  = 1'b1;
                    state_d = StMac;
                end
            end
            StMac:   if (cnt_q == CNT_W'(K)) state_d = StDrain;
            StDrain: state_d = StFin;
            StFin:   state_d = StHold;
            StHold:  if (bus.out_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            bank_q      <= 1'b0;
            swap_pend_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            bank_q      <= bank_d;
            swap_pend_q <= swap_pend_d;
        end
    end

    always_comb begin
        diff   = {z_q[rd_col_q][DW-1], z_q[rd_col_q]} - {off_snap_q[rd_col_q][DW-1], off_snap_q[rd_col_q]};
        prod_c = PW'(coef_rd) * PW'(diff);
    end

    // Three-stage pipe: RAM read, multiply, accumulate; DRAIN covers the last accumulate.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q      <= '0;
            row_q      <= '0;
            col_q      <= '0;
            rd_vld_q   <= 1'b0;
            rd_row_q   <= '0;
            rd_col_q   <= '0;
            prod_vld_q <= 1'b0;
            prod_row_q <= '0;
            prod_q     <= '0;
            for (int i = 0; i < N_IN; i++) begin
                z_q[i]        <= '0;
                off_q[i]      <= '0;
                off_snap_q[i] <= '0;
            end
            for (int o = 0; o < N_OUT; o++) acc_q[o] <= '0;
        end else begin
            if (off_we) off_q[bus.host_addr[COL_W-1:0]] <= bus.host_din[DW-1:0];
            if (accept) begin
                cnt_q <= '0;
                row_q <= '0;
                col_q <= '0;
                for (int i = 0; i < N_IN; i++) begin
                    z_q[i]        <= bus.features[i*DW +: DW];
                    off_snap_q[i] <= off_q[i];
                end
                for (int o = 0; o < N_OUT; o++) acc_q[o] <= '0;
            end else begin
                if (rd_en) begin
                    cnt_q <= cnt_q + 1'b1;
                    if (col_q == COL_W'(N_IN - 1)) begin
                        col_q <= '0;
                        row_q <= row_q + 1'b1;
                    end else begin
                        col_q <= col_q + 1'b1;
                    end
                end
                if (prod_vld_q) acc_q[prod_row_q] <= acc_q[prod_row_q] + ACC_W'(prod_q);
            end
            rd_vld_q   <= rd_en;
            rd_row_q   <= row_q;
            rd_col_q   <= col_q;
            prod_vld_q <= rd_vld_q;
            prod_row_q <= rd_row_q;
            if (rd_vld_q) prod_q <= prod_c;
        end
    end

    always_comb begin
        sat_c = 1'b0;
        u_c   = '0;
        for (int o = 0; o < N_OUT; o++) begin
            biased[o]  = (ACC_W + 1)'(acc_q[o]) + RND;
            shifted[o] = biased[o] >>> SHIFT;
            if (shifted[o] > SAT_MAX) begin
                u_c[o*OW +: OW] = SAT_MAX[OW-1:0];
                sat_c           = 1'b1;
            end else if (shifted[o] < SAT_MIN) begin
                u_c[o*OW +: OW] = SAT_MIN[OW-1:0];
                sat_c           = 1'b1;
            end else begin
                u_c[o*OW +: OW] = shifted[o][OW-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            u_q         <= '0;
            sat_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else if (state_q == StFin) begin
            u_q         <= u_c;
            sat_q       <= sat_c;
            out_valid_q <= 1'b1;
        end else if (state_q == StHold && bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign bus.in_ready    = rst_n && (state_q == StIdle);
    assign bus.out_valid   = out_valid_q;
    assign bus.u           = u_q;
    assign bus.sat_flag    = sat_q;
    assign bus.active_bank = bank_q;

endmodule

// File: tb/tb_boreal_spatial_mixer.sv
// Randomised and directed bench for boreal_spatial_mixer against an arithmetic reference model.
module tb_boreal_spatial_mixer;
    import boreal_spatial_mixer_pkg::*;

    localparam int N_IN  = 8;
    localparam int N_OUT = 2;
    localparam int DW    = 16;
    localparam int CW    = 16;
    localparam int OW    = 24;
    localparam int SHIFT = 8;
    localparam int K     = N_OUT * N_IN;
    localparam int AW    = 4;
    localparam longint MAXV = (longint'(1) <<< (OW - 1)) - 1;
    localparam longint MINV = -(longint'(1) <<< (OW - 1));

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    boreal_spatial_mixer_if #(.N_IN(N_IN), .N_OUT(N_OUT), .DW(DW), .CW(CW), .OW(OW)) bus ();

    boreal_spatial_mixer #(
        .N_IN(N_IN), .N_OUT(N_OUT), .DW(DW), .CW(CW), .ACC_W(40), .SHIFT(SHIFT), .OW(OW)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int     n_checks = 0;
    int     n_pass = 0;
    longint m_coef [2][K];
    longint m_off  [N_IN];
    int     m_bank = 0;
    bit     m_pend = 1'b0;
    longint feat   [N_IN];
    longint exp_u  [N_OUT];
    bit     exp_sat;

    task automatic check_val(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    function automatic longint rand16();
        logic signed [15:0] t;
        t = 16'($urandom());
        return longint'(t);
    endfunction

    function automatic longint get_u(input int o);
        logic signed [OW-1:0] v;
        v = bus.u[o*OW +: OW];
        return longint'(v);
    endfunction

    // u[o] = sat(round(sum coef * (z - off)) / 2^SHIFT)
    task automatic model_frame();
        longint acc, r;
        exp_sat = 1'b0;
        for (int o = 0; o < N_OUT; o++) begin
            acc = 0;
            for (int i = 0; i < N_IN; i++) acc += m_coef[m_bank][o*N_IN+i] * (feat[i] - m_off[i]);
            r = (acc + (longint'(1) <<< (SHIFT - 1))) >>> SHIFT;
            if (r > MAXV) begin r = MAXV; exp_sat = 1'b1; end
            else if (r < MINV) begin r = MINV; exp_sat = 1'b1; end
            exp_u[o] = r;
        end
    endtask

    task automatic host_wr(input logic sel, input int addr, input longint val);
        logic signed [15:0] v;
        v = val[15:0];
        @(negedge clk);
        bus.host_we = 1'b1; bus.host_sel = sel; bus.host_addr = AW'(addr); bus.host_din = v;
        @(negedge clk);
        bus.host_we = 1'b0;
        if (sel == HOST_SEL_COEF) m_coef[m_bank ^ 1][addr] = longint'(v);
        else if (addr < N_IN) m_off[addr] = longint'(v);
    endtask

    task automatic swap_idle(input string tag);
        @(negedge clk); bus.bank_swap = 1'b1;
        @(negedge clk); bus.bank_swap = 1'b0;
        m_bank ^= 1;
        check_val({tag, "_bank"}, bus.active_bank, m_bank);
    endtask

    // action: 0 none, 1 offset write mid-MAC, 2 double swap pulse mid-MAC, 3 reset mid-MAC
    task automatic run_frame(input string tag, input int hold, input int action);
        int n;
        bit seen, stable;
        logic [N_OUT*OW-1:0] saved;
        @(negedge clk);
        check_val({tag, "_in_ready"}, bus.in_ready, 1);
        for (int i = 0; i < N_IN; i++) bus.features[i*DW +: DW] = feat[i][DW-1:0];
        bus.in_valid = 1'b1;
        model_frame();
        @(negedge clk);
        bus.in_valid = 1'b0;
        n = 0;
        seen = 1'b0;
        while (n < 60 && !seen) begin
            if (bus.out_valid) begin
                seen = 1'b1;
            end else begin
                if (action == 1 && n == 5) begin
                    bus.host_we = 1'b1; bus.host_sel = HOST_SEL_OFF; bus.host_addr = AW'(3);
                    bus.host_din = 16'hFF38;
                end
                if (action == 1 && n == 6) begin bus.host_we = 1'b0; m_off[3] = -200; end
                if (action == 2 && (n == 5 || n == 7)) bus.bank_swap = 1'b1;
                if (action == 2 && (n == 6 || n == 8)) begin
                    bus.bank_swap = 1'b0;
                    m_pend = 1'b1;
                    check_val({tag, "_bank_mid"}, bus.active_bank, m_bank);
                end
                if (action == 3 && n == 5) begin
                    rst_n = 1'b0;
                    #1;
                    m_bank = 0; m_pend = 1'b0;
                    for (int i = 0; i < N_IN; i++) m_off[i] = 0;
                    check_val({tag, "_rst_valid"}, bus.out_valid, 0);
                    check_val({tag, "_rst_u"}, longint'(bus.u), 0);
                    check_val({tag, "_rst_bank"}, bus.active_bank, m_bank);
                    check_val({tag, "_rst_ready"}, bus.in_ready, 0);
                    repeat (2) @(negedge clk);
                    rst_n = 1'b1;
                    repeat (2) @(negedge clk);
                    check_val({tag, "_post_valid"}, bus.out_valid, 0);
                    return;
                end
                @(negedge clk);
                n++;
            end
        end
        check_val({tag, "_latency"}, seen ? n : -1, K + 3);
        for (int o = 0; o < N_OUT; o++) check_val($sformatf("%s_u%0d", tag, o), get_u(o), exp_u[o]);
        check_val({tag, "_sat"}, bus.sat_flag, exp_sat);
        saved = bus.u;
        stable = 1'b1;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            if (!bus.out_valid || bus.u != saved || bus.in_ready) stable = 1'b0;
        end
        if (hold > 0) check_val({tag, "_hold"}, stable, 1);
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        check_val({tag, "_xfer"}, bus.out_valid, 0);
        check_val({tag, "_ready_after"}, bus.in_ready, 1);
        @(negedge clk);
        if (m_pend) begin m_bank ^= 1; m_pend = 1'b0; end
        check_val({tag, "_bank_end"}, bus.active_bank, m_bank);
    endtask

    initial begin
        bus.in_valid = 1'b0; bus.features = '0; bus.out_ready = 1'b0; bus.host_we = 1'b0;
        bus.host_sel = 1'b0; bus.host_addr = '0; bus.host_din = '0; bus.bank_swap = 1'b0;
        for (int i = 0; i < N_IN; i++) m_off[i] = 0;
        for (int b = 0; b < 2; b++) for (int k = 0; k < K; k++) m_coef[b][k] = 0;
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_val("rst_in_ready", bus.in_ready, 0);
        check_val("rst_out_valid", bus.out_valid, 0);
        check_val("rst_u", longint'(bus.u), 0);
        check_val("rst_sat", bus.sat_flag, 0);
        check_val("rst_bank", bus.active_bank, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check_val("rel_in_ready", bus.in_ready, 1);

        // Unity-gain rows, all features 100.
        for (int k = 0; k < K; k++) host_wr(HOST_SEL_COEF, k, (k < N_IN || k == N_IN) ? 256 : 0);
        swap_idle("t1");
        for (int i = 0; i < N_IN; i++) feat[i] = 100;
        run_frame("t1", 0, 0);

        for (int i = 0; i < N_IN; i++) host_wr(HOST_SEL_OFF, i, 50);
        run_frame("t2", 0, 1);
        run_frame("t2b", 0, 0);

        // Saturation at both rails.
        for (int k = 0; k < K; k++) host_wr(HOST_SEL_COEF, k, 32767);
        for (int i = 0; i < N_IN; i++) host_wr(HOST_SEL_OFF, i, 0);
        swap_idle("t3");
        for (int i = 0; i < N_IN; i++) feat[i] = 32767;
        run_frame("t3p", 0, 0);
        for (int i = 0; i < N_IN; i++) feat[i] = -32767;
        run_frame("t3n", 0, 0);

        // Swap requested mid-frame applies only once the block is idle.
        for (int k = 0; k < K; k++) host_wr(HOST_SEL_COEF, k, $urandom_range(0, 512));
        for (int i = 0; i < N_IN; i++) feat[i] = $urandom_range(0, 200);
        run_frame("t4", 0, 2);
        run_frame("t4b", 0, 0);

        run_frame("t5", 10, 0);

        run_frame("t6", 0, 3);
        for (int k = 0; k < K; k++) host_wr(HOST_SEL_COEF, k, rand16() / 16);
        swap_idle("t6");
        run_frame("t6b", 0, 0);

        for (int it = 0; it < 6; it++) begin
            for (int k = 0; k < K; k++)
                host_wr(HOST_SEL_COEF, k, rand16() / (longint'(1) <<< $urandom_range(0, 8)));
            for (int i = 0; i < N_IN; i++) host_wr(HOST_SEL_OFF, i, rand16() / 4);
            host_wr(HOST_SEL_OFF, N_IN + 1, rand16());
            swap_idle($sformatf("r%0d", it));
            for (int i = 0; i < N_IN; i++) feat[i] = rand16();
            run_frame($sformatf("r%0d", it), $urandom_range(0, 3), 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
